// File: rtl/dp_operand_framer_pkg.sv
// Shared types and constants for the datapath operand framer.
package dp_pkg;
  localparam int DP_DATAWIDTH    = 32;
  localparam int DP_NUM_OPERANDS = 3;
  localparam int DP_IDX_W        = 2;
  localparam int DP_WCNT_W       = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    OUT     = 2'd3
  } dp_state_e;
endpackage

// File: rtl/dp_operand_framer_if.sv
// Word-stream input and result-stream output of the operand framer.
// master: the feeding/consuming side; slave: the framer.
interface dp_operand_framer_if #(
  parameter int DATAWIDTH = 32
);
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] out_z;
  logic [DATAWIDTH-1:0] out_x;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err_frame;
  logic                 busy;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_z, out_x, out_valid, err_frame, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_z, out_x, out_valid, err_frame, busy
  );
endinterface

// File: rtl/dp_operand_framer_result_hold.sv
// Result holding register: captures z/x on request and holds them with
// out_valid until the consumer takes them.
module dp_result_hold #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 capture_i,
  input  logic [DATAWIDTH-1:0] res_z_i,
  input  logic [DATAWIDTH-1:0] res_x_i,
  input  logic                 ready_i,
  output logic [DATAWIDTH-1:0] z_o,
  output logic [DATAWIDTH-1:0] x_o,
  output logic                 valid_o,
  output logic                 xfer_o
);
  logic [DATAWIDTH-1:0] z_q, x_q;
  logic                 valid_q;

  // Load on capture, drop valid once the result has been taken.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      z_q     <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
    end else if (capture_i) begin
      z_q     <= res_z_i;
      x_q     <= res_x_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign z_o     = z_q;
  assign x_o     = x_q;
  assign valid_o = valid_q;
  assign xfer_o  = valid_q && ready_i;
endmodule

// File: rtl/dp_operand_framer.sv
// Operand framer: collects a/b/c frames from a word stream, holds them for
// LATENCY edges in front of the datapath, then presents captured z/x.
// Optional macro DP_FRAMER_STATS_EN adds frame_cnt / err_cnt outputs.
//
// state   | meaning
// LOAD    | accepting words, idx selects a/b/c
// WAIT    | operands frozen, counting down datapath latency
// CAPTURE | sample res_z/res_x into the result register
// OUT     | result offered, waiting for out_ready
module dp_operand_framer
  import dp_pkg::*;
#(
  parameter int DATAWIDTH = DP_DATAWIDTH,
  parameter int LATENCY   = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
`ifdef DP_FRAMER_STATS_EN
  output logic [15:0]          frame_cnt,
  output logic [7:0]           err_cnt,
`endif
  dp_operand_framer_if.slave   bus,
  output logic [DATAWIDTH-1:0] op_a,
  output logic [DATAWIDTH-1:0] op_b,
  output logic [DATAWIDTH-1:0] op_c,
  input  logic [DATAWIDTH-1:0] res_z,
  input  logic [DATAWIDTH-1:0] res_x
);
  localparam logic [DP_IDX_W-1:0]  IDX_LAST  = DP_IDX_W'(DP_NUM_OPERANDS - 1);
  localparam logic [DP_WCNT_W-1:0] WCNT_INIT = DP_WCNT_W'(LATENCY);

  dp_state_e             state_q;
  logic [DP_IDX_W-1:0]   idx_q;
  logic [DP_WCNT_W-1:0]  wcnt_q;
  logic [DATAWIDTH-1:0]  op_a_q, op_b_q, op_c_q;
  logic                  in_ready_q, busy_q, err_frame_q;
  logic                  in_xfer, res_xfer;

  assign in_xfer = bus.in_valid && in_ready_q;

  // Framing FSM with operand registers; all outputs registered.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      wcnt_q      <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_c_q      <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      err_frame_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (in_xfer) begin
            if (idx_q == '0)           op_a_q <= bus.in_data;
            else if (idx_q == IDX_LAST) op_c_q <= bus.in_data;
            else                        op_b_q <= bus.in_data;

            if (idx_q == IDX_LAST && bus.in_last) begin
              state_q    <= WAIT;
              wcnt_q     <= WCNT_INIT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else if (idx_q == IDX_LAST || bus.in_last) begin
              // Short or overlong frame: drop it and restart at operand a.
              err_frame_q <= 1'b1;
              idx_q       <= '0;
              busy_q      <= 1'b0;
            end else begin
              idx_q  <= idx_q + 1'b1;
              busy_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (wcnt_q == DP_WCNT_W'(1)) state_q <= CAPTURE;
          else                         wcnt_q  <= wcnt_q - 1'b1;
        end
        CAPTURE: begin
          state_q <= OUT;
        end
        OUT: begin
          if (res_xfer) begin
            state_q    <= LOAD;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  dp_result_hold #(.DATAWIDTH(DATAWIDTH)) u_hold (
    .Clk       (Clk),
    .Rst       (Rst),
    .capture_i (state_q == CAPTURE),
    .res_z_i   (res_z),
    .res_x_i   (res_x),
    .ready_i   (bus.out_ready),
    .z_o       (bus.out_z),
    .x_o       (bus.out_x),
    .valid_o   (bus.out_valid),
    .xfer_o    (res_xfer)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.err_frame = err_frame_q;
  assign op_a          = op_a_q;
  assign op_b          = op_b_q;
  assign op_c          = op_c_q;

`ifdef DP_FRAMER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  // Result transfers wrap; framing errors saturate.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (res_xfer) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_frame_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif
endmodule

// File: tb/tb_dp_operand_framer.sv
// Directed bench: dut1 runs with LATENCY=1, dut4 with LATENCY=4.
module tb_dp_operand_framer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] op_a1, op_b1, op_c1, op_a4, op_b4, op_c4;
  logic [31:0] res_z1 = 32'h0, res_x1 = 32'h0;
  logic [31:0] res_z4 = 32'h0, res_x4 = 32'hA5A5_0004;
  int          vecs = 0;
  int          errs = 0;
`ifdef DP_FRAMER_STATS_EN
  logic [15:0] frame_cnt1, frame_cnt4;
  logic [7:0]  err_cnt1, err_cnt4;
`endif

  dp_operand_framer_if #(.DATAWIDTH(32)) bus1();
  dp_operand_framer_if #(.DATAWIDTH(32)) bus4();

  dp_operand_framer #(.DATAWIDTH(32), .LATENCY(1)) dut1 (
    .Clk(clk), .Rst(rst),
`ifdef DP_FRAMER_STATS_EN
    .frame_cnt(frame_cnt1), .err_cnt(err_cnt1),
`endif
    .bus(bus1), .op_a(op_a1), .op_b(op_b1), .op_c(op_c1),
    .res_z(res_z1), .res_x(res_x1)
  );

  dp_operand_framer #(.DATAWIDTH(32), .LATENCY(4)) dut4 (
    .Clk(clk), .Rst(rst),
`ifdef DP_FRAMER_STATS_EN
    .frame_cnt(frame_cnt4), .err_cnt(err_cnt4),
`endif
    .bus(bus4), .op_a(op_a4), .op_b(op_b4), .op_c(op_c4),
    .res_z(res_z4), .res_x(res_x4)
  );

  always #5 clk = ~clk;

  // res_z4 moves every cycle (away from the rising edge) to expose the capture edge.
  always @(negedge clk) res_z4 <= res_z4 + 32'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] d, input logic last);
    bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_last = last;
    tick();
  endtask

  task automatic send4(input logic [31:0] d, input logic last);
    bus4.in_valid = 1'b1; bus4.in_data = d; bus4.in_last = last;
    tick();
  endtask

  task automatic idle();
    bus1.in_valid = 1'b0; bus1.in_last = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    vecs++; if (bus1.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", bus1.in_ready); end
    vecs++; if (bus1.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", bus1.out_valid); end
    vecs++; if ({op_a1, op_b1, op_c1} !== 96'h0) begin errs++; $display("FAIL reset_ops: got %h %h %h want 0", op_a1, op_b1, op_c1); end
    vecs++; if ({bus1.out_z, bus1.out_x} !== 64'h0) begin errs++; $display("FAIL reset_out_zx: got %h %h want 0", bus1.out_z, bus1.out_x); end
    vecs++; if ({bus1.err_frame, bus1.busy} !== 2'b00) begin errs++; $display("FAIL reset_err_busy: got %b want 00", {bus1.err_frame, bus1.busy}); end
  endtask

  task automatic test_happy();
    bus1.out_ready = 1'b1; res_z1 = 32'hDEADBEEF; res_x1 = 32'h0000_0010;
    send1(32'd5, 1'b0);                                      // E0
    vecs++; if (bus1.busy !== 1'b1) begin errs++; $display("FAIL happy_busy: got %b want 1", bus1.busy); end
    send1(32'd3, 1'b0);
    send1(32'd7, 1'b1);                                      // E2
    idle();
    vecs++; if ({op_a1, op_b1, op_c1} !== {32'd5, 32'd3, 32'd7}) begin errs++; $display("FAIL happy_ops: got %0d %0d %0d want 5 3 7", op_a1, op_b1, op_c1); end
    vecs++; if (bus1.in_ready !== 1'b0) begin errs++; $display("FAIL happy_in_ready_wait: got %b want 0", bus1.in_ready); end
    tick();                                                  // E3
    vecs++; if (bus1.out_valid !== 1'b0) begin errs++; $display("FAIL happy_early_valid: got %b want 0", bus1.out_valid); end
    tick();                                                  // E4
    vecs++; if (bus1.out_valid !== 1'b1) begin errs++; $display("FAIL happy_valid: got %b want 1", bus1.out_valid); end
    vecs++; if (bus1.out_z !== 32'hDEADBEEF) begin errs++; $display("FAIL happy_out_z: got %h want deadbeef", bus1.out_z); end
    vecs++; if (bus1.out_x !== 32'h10) begin errs++; $display("FAIL happy_out_x: got %h want 10", bus1.out_x); end
    tick();                                                  // E5 transfer
    vecs++; if ({bus1.out_valid, bus1.in_ready} !== 2'b01) begin errs++; $display("FAIL happy_after_xfer: got %b want 01", {bus1.out_valid, bus1.in_ready}); end
  endtask

  task automatic test_early_last();
    res_z1 = 32'h0000_1234; res_x1 = 32'h0000_5678;
    send1(32'd9, 1'b0);
    send1(32'd8, 1'b1);
    idle();
    vecs++; if ({bus1.err_frame, bus1.in_ready, bus1.busy} !== 3'b110) begin errs++; $display("FAIL early_err: got err/rdy/busy %b want 110", {bus1.err_frame, bus1.in_ready, bus1.busy}); end
    vecs++; if ({op_a1, op_b1, op_c1} !== {32'd9, 32'd8, 32'd7}) begin errs++; $display("FAIL early_ops_kept: got %0d %0d %0d want 9 8 7", op_a1, op_b1, op_c1); end
    tick();
    vecs++; if ({bus1.err_frame, bus1.out_valid} !== 2'b00) begin errs++; $display("FAIL early_pulse_once: got err/valid %b want 00", {bus1.err_frame, bus1.out_valid}); end
    send1(32'd1, 1'b0); send1(32'd2, 1'b0); send1(32'd3, 1'b1);
    idle();
    vecs++; if ({op_a1, op_b1, op_c1} !== {32'd1, 32'd2, 32'd3}) begin errs++; $display("FAIL early_good_ops: got %0d %0d %0d want 1 2 3", op_a1, op_b1, op_c1); end
    tick(); tick();
    vecs++; if ({bus1.out_valid, bus1.out_z, bus1.out_x} !== {1'b1, 32'h1234, 32'h5678}) begin errs++; $display("FAIL early_good_result: got %b %h %h want 1 1234 5678", bus1.out_valid, bus1.out_z, bus1.out_x); end
    tick();
  endtask

  task automatic test_missing_last();
    res_z1 = 32'hCAFE_0001; res_x1 = 32'hCAFE_0002;
    send1(32'd11, 1'b0); send1(32'd12, 1'b0); send1(32'd13, 1'b0);
    idle();
    vecs++; if ({bus1.err_frame, bus1.busy, bus1.in_ready} !== 3'b101) begin errs++; $display("FAIL missing_err: got err/busy/rdy %b want 101", {bus1.err_frame, bus1.busy, bus1.in_ready}); end
    send1(32'd21, 1'b0); send1(32'd22, 1'b0); send1(32'd23, 1'b1);
    idle();
    vecs++; if ({op_a1, op_b1, op_c1} !== {32'd21, 32'd22, 32'd23}) begin errs++; $display("FAIL missing_new_frame: got %0d %0d %0d want 21 22 23", op_a1, op_b1, op_c1); end
    vecs++; if (bus1.err_frame !== 1'b0) begin errs++; $display("FAIL missing_no_err: got %b want 0", bus1.err_frame); end
    tick(); tick();
    vecs++; if ({bus1.out_valid, bus1.out_z} !== {1'b1, 32'hCAFE_0001}) begin errs++; $display("FAIL missing_result: got %b %h want 1 cafe0001", bus1.out_valid, bus1.out_z); end
    tick();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    bus1.out_ready = 1'b0; res_z1 = 32'h0BAD_F00D; res_x1 = 32'h0000_00AA;
    send1(32'd4, 1'b0); send1(32'd5, 1'b0); send1(32'd6, 1'b1);
    idle();
    tick(); tick();
    res_z1 = 32'h1111_1111; res_x1 = 32'h2222_2222;
    bus1.in_valid = 1'b1; bus1.in_data = 32'd77; bus1.in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ({bus1.out_valid, bus1.in_ready, bus1.out_z, bus1.out_x, op_a1} !==
          {1'b1, 1'b0, 32'h0BAD_F00D, 32'h0000_00AA, 32'd4}) bad++;
      tick();
    end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
    bus1.out_ready = 1'b1;
    tick();
    vecs++; if ({bus1.out_valid, bus1.in_ready, op_a1} !== {1'b0, 1'b1, 32'd4}) begin errs++; $display("FAIL bp_xfer: got %b %b %0d want 0 1 4", bus1.out_valid, bus1.in_ready, op_a1); end
    tick();
    idle();
    vecs++; if ({op_a1, bus1.busy} !== {32'd77, 1'b1}) begin errs++; $display("FAIL bp_next_word: got %0d %b want 77 1", op_a1, bus1.busy); end
  endtask

  task automatic test_latency4();
    int bad = 0;
    logic [31:0] exp_z;
    bus4.out_ready = 1'b1;
    send4(32'hA, 1'b0); send4(32'hB, 1'b0); send4(32'hC, 1'b1);   // E0..E2
    idle();
    for (int i = 0; i < 4; i++) begin                                // E3..E6
      tick();
      if ({bus4.out_valid, op_a4, op_b4, op_c4} !== {1'b0, 32'hA, 32'hB, 32'hC}) bad++;
    end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL lat4_stable: %0d bad cycles want 0", bad); end
    exp_z = res_z4 + 32'd1;
    tick();                                                          // E7 capture
    vecs++; if ({bus4.out_valid, bus4.out_z, bus4.out_x} !== {1'b1, exp_z, 32'hA5A5_0004}) begin errs++; $display("FAIL lat4_capture: got %b %h %h want 1 %h a5a50004", bus4.out_valid, bus4.out_z, bus4.out_x, exp_z); end
    tick();
    vecs++; if ({bus4.out_valid, bus4.in_ready} !== 2'b01) begin errs++; $display("FAIL lat4_xfer: got %b want 01", {bus4.out_valid, bus4.in_ready}); end
  endtask

  task automatic test_stats();
`ifdef DP_FRAMER_STATS_EN
    vecs++; if (frame_cnt1 !== 16'd4) begin errs++; $display("FAIL stats_frame_cnt: got %0d want 4", frame_cnt1); end
    vecs++; if (err_cnt1 !== 8'd2) begin errs++; $display("FAIL stats_err_cnt: got %0d want 2", err_cnt1); end
    vecs++; if (frame_cnt4 !== 16'd1) begin errs++; $display("FAIL stats_frame_cnt4: got %0d want 1", frame_cnt4); end
`endif
  endtask

  task automatic test_reset_in_wait();
    int bad = 0;
    bus4.out_ready = 1'b1;
    send4(32'd31, 1'b0); send4(32'd32, 1'b0); send4(32'd33, 1'b1);
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++; if ({bus4.out_valid, bus4.in_ready, bus4.busy} !== 3'b010) begin errs++; $display("FAIL rstwait_ctrl: got valid/rdy/busy %b want 010", {bus4.out_valid, bus4.in_ready, bus4.busy}); end
    vecs++; if ({op_a4, op_b4, op_c4} !== 96'h0) begin errs++; $display("FAIL rstwait_ops: got %h %h %h want 0", op_a4, op_b4, op_c4); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus4.out_valid !== 1'b0) bad++;
    end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL rstwait_no_result: %0d cycles with out_valid want 0", bad); end
`ifdef DP_FRAMER_STATS_EN
    vecs++; if (frame_cnt4 !== 16'd0) begin errs++; $display("FAIL rstwait_frame_cnt: got %0d want 0", frame_cnt4); end
`endif
  endtask

  initial begin
    bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.out_ready = 1'b0;
    bus4.in_data = '0; bus4.in_valid = 1'b0; bus4.in_last = 1'b0; bus4.out_ready = 1'b0;
    test_reset();
    test_happy();
    test_early_last();
    test_missing_last();
    test_backpressure();
    test_latency4();
    test_stats();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dp_operand_framer.md
Name: dp_operand_framer

Overview:
- Upstream feeder for the generated 32-bit datapath circuits (ADD/SUB/COMP/MUX/SHx/REG netlists with operands a, b, c and registered outputs z, x).
- Accepts a serial word stream over valid/ready and assembles each frame of three operands.
- Holds the operands stable across the datapath's register latency, then captures z/x and presents them on a valid/ready result port.
- Turns the free-running datapath into a transaction-based unit.

Parameters:
- DATAWIDTH, 32, width of every operand and result word.
- LATENCY, 1, clock edges from operands stable to valid z/x at the datapath outputs; legal range 1..15.

Ports:
- Clk  input  1  single system clock, rising edge.
- Rst  input  1  synchronous, active-high reset.
- in_data  input  DATAWIDTH  operand word; frame order a, b, c.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks final word of a frame; qualified by in_valid.
- in_ready  output  1  framer accepts a word this cycle.
- op_a  output  DATAWIDTH  registered operand to datapath input a.
- op_b  output  DATAWIDTH  registered operand to datapath input b.
- op_c  output  DATAWIDTH  registered operand to datapath input c.
- res_z  input  DATAWIDTH  datapath output z.
- res_x  input  DATAWIDTH  datapath output x.
- out_z  output  DATAWIDTH  captured z.
- out_x  output  DATAWIDTH  captured x.
- out_valid  output  1  out_z/out_x valid.
- out_ready  input  1  consumer accepts result.
- err_frame  output  1  one-cycle pulse on a framing error.
- busy  output  1  high in every state except LOAD with word index 0.

Behaviour:
- Clock and reset:
  - One clock, Clk. Reset is synchronous and active-high on Rst.
  - Reset is sampled at the Clk edge and overrides all other activity.
  - Reset values: state=LOAD, idx=0, op_a/op_b/op_c=0, out_z/out_x=0, out_valid=0, err_frame=0, in_ready=1 in the cycle after reset.
  - Reset mid-frame or mid-wait discards all partial data. No result is emitted.
- Transfers:
  - A word transfers when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
- FSM LOAD:
  - in_ready=1.
  - Each transfer writes op_a (idx 0), op_b (idx 1) or op_c (idx 2), then increments idx.
  - in_last on idx 0 or 1: err_frame=1 next cycle, idx←0, stay LOAD. Operands already written keep their values.
  - idx 2 without in_last: err_frame=1 next cycle, idx←0, stay LOAD.
  - idx 2 with in_last: go to WAIT, wcnt←LATENCY.
- FSM WAIT:
  - in_ready=0.
  - op_* are held constant.
  - wcnt decrements each cycle. At wcnt==1, go to CAPTURE.
  - This gives exactly LATENCY edges of stable operands before capture.
- FSM CAPTURE:
  - One cycle. out_z←res_z, out_x←res_x, out_valid←1, go to OUT.
- FSM OUT:
  - in_ready=0.
  - out_valid, out_z and out_x are held until out_ready.
  - On transfer: out_valid←0, idx←0, go to LOAD.
  - There is no combinational path from out_ready to in_ready. The next frame's first word is accepted no earlier than the cycle after the result transfer.
- Timing:
  - First word to out_valid = 3 + LATENCY cycles minimum.
  - Throughput is one frame per 5 + LATENCY cycles with no stalls.
- Signal rules:
  - in_last without in_valid is ignored.
  - in_data is not checked when in_valid=0.
  - err_frame never coincides with out_valid rising.
  - op_* change only on an accepted LOAD word.

Optional Feature:
- Macro: DP_FRAMER_STATS_EN.
- When defined, adds the following output ports:
  - frame_cnt (16 bits): increments on each result transfer, wraps at 16'hFFFF→0.
  - err_cnt (8 bits): increments on each err_frame, saturates at 8'hFF.
  - Both counters reset to 0.
- When undefined, neither port nor its counter logic exists, and all other behaviour is identical.

Decomposition:
- Package dp_pkg:
  - State enum: LOAD, WAIT, CAPTURE, OUT.
  - Constants: DP_DATAWIDTH=32, DP_NUM_OPERANDS=3, DP_IDX_W=2, DP_WCNT_W=4.
- Sub-module dp_result_hold: the out_z/out_x/out_valid holding register with the valid/ready handshake. The FSM and operand registers stay in the top.

Test Plan:
- Happy path: send a=5, b=3, c=7 (in_last on 7), out_ready=1, LATENCY=1, stub res_z=32'hDEADBEEF, res_x=32'h0000_0010. Required: op_a/op_b/op_c=5/3/7, out_valid rises 4 cycles after the first word, out_z=DEADBEEF, out_x=10.
- Early in_last on the 2nd word: err_frame pulses once, in_ready stays 1, no out_valid. A following good frame 1/2/3 completes normally.
- Missing in_last on the 3rd word: err_frame pulses, idx returns to 0. The next three words form a new frame.
- Backpressure: out_ready=0 for 10 cycles after out_valid. out_z/out_x/out_valid stay stable, in_ready=0 throughout. First word accepted the cycle after out_ready=1.
- LATENCY=4: op_* stable for 4 edges, and capture samples res_z at the edge after the 4th. Bench changes res_z every cycle to check the sample point.
- Reset asserted in WAIT: next cycle out_valid=0, op_*=0, in_ready=1, no result ever emitted. Stats build: frame_cnt=0.
